// File: rtl/reg_writeback_arbiter.sv
// Register-file writeback arbiter: merges single-cycle ALU results with buffered
// mul/div results and keeps a per-register pending mask for ordering checks.
module reg_writeback_arbiter #(
    parameter int MD_FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALU_VALID,
    input  logic [4:0]  ALU_RD,
    input  logic [31:0] ALU_DATA,
    input  logic        MD_VALID,
    input  logic [4:0]  MD_RD,
    input  logic [31:0] MD_DATA,
    output logic        MD_READY,
    input  logic        ISSUE_VALID,
    input  logic [4:0]  ISSUE_RD,
    output logic        WRITE_ENABLE,
    output logic [4:0]  WRITE_ADDRESS,
    output logic [31:0] WRITE_DATA,
    output logic [31:0] BUSY_MASK,
    output logic        WAW_ERR
);

    localparam int AW = $clog2(MD_FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(MD_FIFO_DEPTH);

    logic [4:0]    fifo_rd   [MD_FIFO_DEPTH];
    logic [31:0]   fifo_data [MD_FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic        alu_sel;
    logic        fifo_empty;
    logic        md_accept;
    logic        pop;
    logic        bypass;
    logic        push;
    logic        md_sel;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    // MD handshake: a result transfers on a rising edge where MD_VALID and
    // MD_READY are both high; MD_READY depends only on occupancy and RESET.
    assign MD_READY   = !RESET && (count < DEPTH_CNT);
    assign md_accept  = MD_VALID && MD_READY;
    assign fifo_empty = (count == '0);

    // An ALU result to x0 does not claim the port, so the MD side may drain.
    assign alu_sel = ALU_VALID && (ALU_RD != 5'd0);
    assign pop     = !alu_sel && !fifo_empty;
    assign bypass  = !alu_sel && fifo_empty && md_accept;
    assign push    = md_accept && !bypass;
    assign md_sel  = pop || bypass;

    assign sel_rd   = pop ? fifo_rd[rd_ptr]   : MD_RD;
    assign sel_data = pop ? fifo_data[rd_ptr] : MD_DATA;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (ISSUE_VALID) set_vec[ISSUE_RD] = 1'b1;
        if (md_sel)      clr_vec[sel_rd]   = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= MD_RD;
            fifo_data[wr_ptr] <= MD_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            WRITE_ENABLE  <= 1'b0;
            WRITE_ADDRESS <= '0;
            WRITE_DATA    <= '0;
            BUSY_MASK     <= '0;
            WAW_ERR       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (alu_sel) begin
                WRITE_ENABLE  <= 1'b1;
                WRITE_ADDRESS <= ALU_RD;
                WRITE_DATA    <= ALU_DATA;
            end else if (md_sel) begin
                WRITE_ENABLE  <= (sel_rd != 5'd0);
                WRITE_ADDRESS <= sel_rd;
                WRITE_DATA    <= sel_data;
            end else begin
                WRITE_ENABLE  <= 1'b0;
                WRITE_ADDRESS <= '0;
                WRITE_DATA    <= '0;
            end

            // Set after clear so a same-edge issue keeps the bit; x0 never tracks.
            BUSY_MASK <= ((BUSY_MASK & ~clr_vec) | set_vec) & ~32'd1;

            if (alu_sel && BUSY_MASK[ALU_RD]) WAW_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: a per-cycle vector table plus
// hand-written backpressure and mid-operation reset sequences.
module tb_reg_writeback_arbiter;

    logic        CLK;
    logic        RESET;
    logic        ALU_VALID;
    logic [4:0]  ALU_RD;
    logic [31:0] ALU_DATA;
    logic        MD_VALID;
    logic [4:0]  MD_RD;
    logic [31:0] MD_DATA;
    logic        MD_READY;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RD;
    logic        WRITE_ENABLE;
    logic [4:0]  WRITE_ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] BUSY_MASK;
    logic        WAW_ERR;

    int total = 0;
    int bad   = 0;

    reg_writeback_arbiter #(.MD_FIFO_DEPTH(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
        .MD_VALID(MD_VALID), .MD_RD(MD_RD), .MD_DATA(MD_DATA), .MD_READY(MD_READY),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
        .WRITE_ENABLE(WRITE_ENABLE), .WRITE_ADDRESS(WRITE_ADDRESS), .WRITE_DATA(WRITE_DATA),
        .BUSY_MASK(BUSY_MASK), .WAW_ERR(WAW_ERR)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        iv;
        logic [4:0]  ird;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_busy;
        logic        e_waw;
    } vec_t;

    vec_t vecs [20];
    logic [36:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic av, input logic [4:0] ard,
                         input logic [31:0] adat, input logic mv, input logic [4:0] mrd,
                         input logic [31:0] mdat, input logic iv, input logic [4:0] ird);
        RESET = rst; ALU_VALID = av; ALU_RD = ard; ALU_DATA = adat;
        MD_VALID = mv; MD_RD = mrd; MD_DATA = mdat; ISSUE_VALID = iv; ISSUE_RD = ird;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // compare one write against the head of the expected write stream
    task automatic check_write(input string name);
        logic [36:0] e;
        chk({name, "_we"}, 32'(WRITE_ENABLE), 32'd1);
        if (exp_q.size() == 0) begin
            chk({name, "_queue"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_addr"}, 32'(WRITE_ADDRESS), 32'(e[36:32]));
            chk({name, "_data"}, WRITE_DATA, e[31:0]);
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //           rst av ard  adat      mv mrd mdat      iv ird  rdy we addr data      busy     waw
        vecs[0]  = '{1, 0, 0,  32'h0,    0, 0,  32'h0,    0, 0,   0,  0, 0,  32'h0,    32'h0,   0};
        vecs[1]  = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    0, 0,   1,  0, 0,  32'h0,    32'h0,   0};
        vecs[2]  = '{0, 1, 5,  32'h11,   1, 6,  32'h22,   0, 0,   1,  1, 5,  32'h11,   32'h0,   0};
        vecs[3]  = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    0, 0,   1,  1, 6,  32'h22,   32'h0,   0};
        vecs[4]  = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    1, 7,   1,  0, 0,  32'h0,    32'h80,  0};
        vecs[5]  = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    0, 0,   1,  0, 0,  32'h0,    32'h80,  0};
        vecs[6]  = '{0, 0, 0,  32'h0,    1, 7,  32'hABCD, 0, 0,   1,  1, 7,  32'hABCD, 32'h0,   0};
        vecs[7]  = '{0, 1, 0,  32'hFFFF, 0, 0,  32'h0,    1, 0,   1,  0, 0,  32'h0,    32'h0,   0};
        vecs[8]  = '{0, 1, 9,  32'h5,    1, 8,  32'h88,   0, 0,   1,  1, 9,  32'h5,    32'h0,   0};
        vecs[9]  = '{0, 1, 0,  32'hFFFF, 0, 0,  32'h0,    0, 0,   1,  1, 8,  32'h88,   32'h0,   0};
        vecs[10] = '{0, 0, 0,  32'h0,    1, 0,  32'h77,   0, 0,   1,  0, 0,  32'h0,    32'h0,   0};
        vecs[11] = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    1, 3,   1,  0, 0,  32'h0,    32'h8,   0};
        vecs[12] = '{0, 1, 3,  32'h1,    0, 0,  32'h0,    0, 0,   1,  1, 3,  32'h1,    32'h8,   1};
        vecs[13] = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    0, 0,   1,  0, 0,  32'h0,    32'h8,   1};
        vecs[14] = '{1, 1, 5,  32'h55,   1, 9,  32'h99,   1, 9,   0,  0, 0,  32'h0,    32'h0,   0};
        vecs[15] = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    0, 0,   1,  0, 0,  32'h0,    32'h0,   0};
        vecs[16] = '{0, 0, 0,  32'h0,    0, 0,  32'h0,    1, 4,   1,  0, 0,  32'h0,    32'h10,  0};
        vecs[17] = '{0, 0, 0,  32'h0,    1, 4,  32'h44,   1, 4,   1,  1, 4,  32'h44,   32'h10,  0};
        vecs[18] = '{0, 0, 0,  32'h0,    1, 4,  32'h45,   0, 0,   1,  1, 4,  32'h45,   32'h0,   0};
        vecs[19] = '{0, 0, 0,  32'h0,    1, 12, 32'hC,    0, 0,   1,  1, 12, 32'hC,    32'h0,   0};

        #1;
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv,
                  vecs[i].mrd, vecs[i].mdat, vecs[i].iv, vecs[i].ird);
            #1;
            chk($sformatf("v%0d_md_ready", i), 32'(MD_READY), 32'(vecs[i].e_rdy));
            step();
            chk($sformatf("v%0d_we", i), 32'(WRITE_ENABLE), 32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_addr", i), 32'(WRITE_ADDRESS), 32'(vecs[i].e_addr));
                chk($sformatf("v%0d_data", i), WRITE_DATA, vecs[i].e_data);
            end
            chk($sformatf("v%0d_busy", i), BUSY_MASK, vecs[i].e_busy);
            chk($sformatf("v%0d_waw", i), 32'(WAW_ERR), 32'(vecs[i].e_waw));
        end

        // backpressure: ALU holds the port 4 cycles while 3 MD results are offered
        exp_q = {};
        for (int k = 0; k < 4; k++) exp_q.push_back({5'd1, 32'hA1 + 32'(k)});
        exp_q.push_back({5'd10, 32'h100});
        exp_q.push_back({5'd11, 32'h101});
        exp_q.push_back({5'd12, 32'h102});

        drive(0, 1, 1, 32'hA1, 1, 10, 32'h100, 0, 0); #1;
        chk("bp0_ready", 32'(MD_READY), 32'd1);
        step(); check_write("bp0");
        drive(0, 1, 1, 32'hA2, 1, 11, 32'h101, 0, 0); #1;
        chk("bp1_ready", 32'(MD_READY), 32'd1);
        step(); check_write("bp1");
        drive(0, 1, 1, 32'hA3, 1, 12, 32'h102, 0, 0); #1;
        chk("bp2_ready", 32'(MD_READY), 32'd0);
        step(); check_write("bp2");
        drive(0, 1, 1, 32'hA4, 1, 12, 32'h102, 0, 0); #1;
        chk("bp3_ready", 32'(MD_READY), 32'd0);
        step(); check_write("bp3");
        drive(0, 0, 0, 32'h0, 1, 12, 32'h102, 0, 0); #1;
        chk("bp4_ready", 32'(MD_READY), 32'd0);
        step(); check_write("bp4");
        #1;
        chk("bp5_ready", 32'(MD_READY), 32'd1);
        step(); check_write("bp5");
        idle(); #1;
        step(); check_write("bp6");
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        step();
        chk("bp_idle_we", 32'(WRITE_ENABLE), 32'd0);

        // reset while two MD results are buffered and x3/x4 are pending
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3); step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4); step();
        drive(0, 1, 1, 32'hB1, 1, 3, 32'h33, 0, 0); step();
        drive(0, 1, 1, 32'hB2, 1, 4, 32'h34, 0, 0); #1;
        chk("rm_ready_pre", 32'(MD_READY), 32'd1);
        step();
        chk("rm_busy", BUSY_MASK, 32'h18);
        chk("rm_full", 32'(MD_READY), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("rm_ready_in_reset", 32'(MD_READY), 32'd0);
        step();
        idle(); #1;
        chk("rm_ready_after", 32'(MD_READY), 32'd1);
        chk("rm_busy_after", BUSY_MASK, 32'h0);
        chk("rm_we_reset", 32'(WRITE_ENABLE), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rm_we_%0d", k), 32'(WRITE_ENABLE), 32'd0);
            chk($sformatf("rm_busy_%0d", k), BUSY_MASK, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
